// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : WISC-SP13 memory stage and MEM/WB register with req/done memory
//            handshake. Optional macro MEM_TIMEOUT_EN adds a WAIT watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Valid_In_FromEx,
  input  logic        MemRead_In_FromEx,
  input  logic        MemWrite_In_FromEx,
  input  logic [15:0] ALUResult_In_FromEx,
  input  logic [15:0] WriteData_In_FromEx,
  input  logic [2:0]  WR_In_FromEx,
  input  logic        WriteToReg_In_FromEx,
  input  logic        RegWriteDataSel_In_FromEx,
  input  logic        Halt_In_FromEx,
  output logic        MemReq_Out,
  output logic        MemWr_Out,
  output logic [15:0] MemAddr_Out,
  output logic [15:0] MemWData_Out,
  input  logic [15:0] MemRData_In,
  input  logic        MemDone_In,
  output logic        Stall_Out_ToPipe,
  output logic [15:0] ReadData_Out_ToWB,
  output logic [15:0] ALUResult_Out_ToWB,
  output logic [2:0]  WR_Out_ToWB,
  output logic        WriteToReg_Out_ToWB,
  output logic        RegWriteDataSel_Out_ToWB,
  output logic        Halt_Out_ToWB,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_h_alu;
  logic [15:0] r_h_wdata;
  logic        r_h_mwr;
  logic        r_h_mrd;
  logic [2:0]  r_h_dst;
  logic        r_h_wtr;
  logic        r_h_sel;
  logic        r_h_halt;

  logic [15:0] r_wb_rdata;
  logic [15:0] r_wb_alu;
  logic [2:0]  r_wb_dst;
  logic        r_wb_wtr;
  logic        r_wb_sel;
  logic        r_wb_halt;
  logic        r_err;

  logic        w_mem_op;
  logic        w_rw_both;
  logic        w_req;
  logic        w_mwr;
  logic [15:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_stall;
  logic        w_capture;
  logic        w_wb_load;
  logic        w_wb_from_hold;
  logic        w_wb_bubble;
  logic        w_halt_hold;
  logic        w_err_set;
  logic        w_cnt_clr;
  logic        w_timeout;

  assign w_mem_op  = Valid_In_FromEx & (MemRead_In_FromEx | MemWrite_In_FromEx);
  assign w_rw_both = Valid_In_FromEx & MemRead_In_FromEx & MemWrite_In_FromEx;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_tmo_cnt == c_tmo_last) && !MemDone_In;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^{c_tmo_last, w_cnt_clr};
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req          = 1'b0;
    w_mwr          = 1'b0;
    w_addr         = '0;
    w_wdata        = '0;
    w_stall        = 1'b0;
    w_capture      = 1'b0;
    w_wb_load      = 1'b0;
    w_wb_from_hold = 1'b0;
    w_wb_bubble    = 1'b0;
    w_halt_hold    = 1'b0;
    w_err_set      = 1'b0;
    w_cnt_clr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rw_both) begin
          // Conflicting read+write: flag it and squash the instruction.
          w_err_set   = 1'b1;
          w_wb_bubble = 1'b1;
        end else if (w_mem_op) begin
          w_req     = 1'b1;
          w_mwr     = MemWrite_In_FromEx;
          w_addr    = {ALUResult_In_FromEx[15:1], 1'b0};
          w_wdata   = WriteData_In_FromEx;
          w_capture = 1'b1;
          w_err_set = ALUResult_In_FromEx[0];
          if (MemDone_In) begin
            w_wb_load = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_stall     = 1'b1;
            w_wb_bubble = 1'b1;
            w_cnt_clr   = 1'b1;
          end
        end else if (Valid_In_FromEx) begin
          w_wb_load = 1'b1;
          if (Halt_In_FromEx) begin
            w_state_nxt = S_HALTED;
          end
        end else begin
          w_wb_bubble = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_timeout) begin
          w_err_set   = 1'b1;
          w_wb_bubble = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_req   = 1'b1;
          w_mwr   = r_h_mwr;
          w_addr  = {r_h_alu[15:1], 1'b0};
          w_wdata = r_h_wdata;
          w_stall = ~MemDone_In;
          if (MemDone_In) begin
            w_wb_load      = 1'b1;
            w_wb_from_hold = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_wb_bubble = 1'b1;
          end
        end
      end
      S_HALTED: begin
        w_halt_hold = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_alu    <= '0;
      r_h_wdata  <= '0;
      r_h_mwr    <= 1'b0;
      r_h_mrd    <= 1'b0;
      r_h_dst    <= '0;
      r_h_wtr    <= 1'b0;
      r_h_sel    <= 1'b0;
      r_h_halt   <= 1'b0;
      r_wb_rdata <= '0;
      r_wb_alu   <= '0;
      r_wb_dst   <= '0;
      r_wb_wtr   <= 1'b0;
      r_wb_sel   <= 1'b0;
      r_wb_halt  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_capture) begin
        r_h_alu   <= ALUResult_In_FromEx;
        r_h_wdata <= WriteData_In_FromEx;
        r_h_mwr   <= MemWrite_In_FromEx;
        r_h_mrd   <= MemRead_In_FromEx;
        r_h_dst   <= WR_In_FromEx;
        r_h_wtr   <= WriteToReg_In_FromEx;
        r_h_sel   <= RegWriteDataSel_In_FromEx;
        r_h_halt  <= Halt_In_FromEx;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_wb_load) begin
        if (w_wb_from_hold) begin
          if (r_h_mrd) begin
            r_wb_rdata <= MemRData_In;
          end
          r_wb_alu  <= r_h_alu;
          r_wb_dst  <= r_h_dst;
          r_wb_wtr  <= r_h_wtr;
          r_wb_sel  <= r_h_sel;
          r_wb_halt <= r_h_halt;
        end else begin
          if (MemRead_In_FromEx) begin
            r_wb_rdata <= MemRData_In;
          end
          r_wb_alu  <= ALUResult_In_FromEx;
          r_wb_dst  <= WR_In_FromEx;
          r_wb_wtr  <= WriteToReg_In_FromEx;
          r_wb_sel  <= RegWriteDataSel_In_FromEx;
          r_wb_halt <= Halt_In_FromEx;
        end
      end else if (w_wb_bubble) begin
        // Bubbles keep the data fields and only kill side effects.
        r_wb_wtr  <= 1'b0;
        r_wb_halt <= 1'b0;
      end else if (w_halt_hold) begin
        r_wb_wtr <= 1'b0;
      end
    end
  end

  // Request-side outputs are gated so they drop the instant reset asserts.
  assign MemReq_Out       = w_req & rst_n;
  assign MemWr_Out        = w_mwr & rst_n;
  assign MemAddr_Out      = w_addr & {16{rst_n}};
  assign MemWData_Out     = w_wdata & {16{rst_n}};
  assign Stall_Out_ToPipe = w_stall & rst_n;

  assign ReadData_Out_ToWB        = r_wb_rdata;
  assign ALUResult_Out_ToWB       = r_wb_alu;
  assign WR_Out_ToWB              = r_wb_dst;
  assign WriteToReg_Out_ToWB      = r_wb_wtr;
  assign RegWriteDataSel_Out_ToWB = r_wb_sel;
  assign Halt_Out_ToWB            = r_wb_halt;
  assign err                      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking scoreboard bench for mem_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Valid_In_FromEx;
  logic        MemRead_In_FromEx;
  logic        MemWrite_In_FromEx;
  logic [15:0] ALUResult_In_FromEx;
  logic [15:0] WriteData_In_FromEx;
  logic [2:0]  WR_In_FromEx;
  logic        WriteToReg_In_FromEx;
  logic        RegWriteDataSel_In_FromEx;
  logic        Halt_In_FromEx;
  logic        MemReq_Out;
  logic        MemWr_Out;
  logic [15:0] MemAddr_Out;
  logic [15:0] MemWData_Out;
  logic [15:0] MemRData_In;
  logic        MemDone_In;
  logic        Stall_Out_ToPipe;
  logic [15:0] ReadData_Out_ToWB;
  logic [15:0] ALUResult_Out_ToWB;
  logic [2:0]  WR_Out_ToWB;
  logic        WriteToReg_Out_ToWB;
  logic        RegWriteDataSel_Out_ToWB;
  logic        Halt_Out_ToWB;
  logic        err;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .Valid_In_FromEx          (Valid_In_FromEx),
    .MemRead_In_FromEx        (MemRead_In_FromEx),
    .MemWrite_In_FromEx       (MemWrite_In_FromEx),
    .ALUResult_In_FromEx      (ALUResult_In_FromEx),
    .WriteData_In_FromEx      (WriteData_In_FromEx),
    .WR_In_FromEx             (WR_In_FromEx),
    .WriteToReg_In_FromEx     (WriteToReg_In_FromEx),
    .RegWriteDataSel_In_FromEx(RegWriteDataSel_In_FromEx),
    .Halt_In_FromEx           (Halt_In_FromEx),
    .MemReq_Out               (MemReq_Out),
    .MemWr_Out                (MemWr_Out),
    .MemAddr_Out              (MemAddr_Out),
    .MemWData_Out             (MemWData_Out),
    .MemRData_In              (MemRData_In),
    .MemDone_In               (MemDone_In),
    .Stall_Out_ToPipe         (Stall_Out_ToPipe),
    .ReadData_Out_ToWB        (ReadData_Out_ToWB),
    .ALUResult_Out_ToWB       (ALUResult_Out_ToWB),
    .WR_Out_ToWB              (WR_Out_ToWB),
    .WriteToReg_Out_ToWB      (WriteToReg_Out_ToWB),
    .RegWriteDataSel_Out_ToWB (RegWriteDataSel_Out_ToWB),
    .Halt_Out_ToWB            (Halt_Out_ToWB),
    .err                      (err)
  );

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] alu;
    logic [2:0]  dst;
    logic        wtr;
    logic        sel;
    logic        halt;
  } wb_t;

  wb_t         sb[$];
  wb_t         obs;
  wb_t         exp_wb;
  logic [15:0] m_rd;
  logic [73:0] all_out;
  int          checks = 0;
  int          errors = 0;

  assign obs = {ReadData_Out_ToWB, ALUResult_Out_ToWB, WR_Out_ToWB,
                WriteToReg_Out_ToWB, RegWriteDataSel_Out_ToWB, Halt_Out_ToWB};
  assign all_out = {MemReq_Out, MemWr_Out, MemAddr_Out, MemWData_Out, Stall_Out_ToPipe,
                    obs, err};

  function automatic wb_t mk(input logic [15:0] rd, input logic [15:0] alu,
                             input logic [2:0] dst, input logic wtr,
                             input logic sel, input logic halt);
    mk = {rd, alu, dst, wtr, sel, halt};
  endfunction

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [15:0] alu, input logic [15:0] wd,
                       input logic [2:0] dst, input logic wtr,
                       input logic sel, input logic halt);
    Valid_In_FromEx           = v;
    MemRead_In_FromEx         = rd;
    MemWrite_In_FromEx        = wr;
    ALUResult_In_FromEx       = alu;
    WriteData_In_FromEx       = wd;
    WR_In_FromEx              = dst;
    WriteToReg_In_FromEx      = wtr;
    RegWriteDataSel_In_FromEx = sel;
    Halt_In_FromEx            = halt;
  endtask

  task automatic drive_idle;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_mem(input logic done, input logic [15:0] rdata);
    MemDone_In  = done;
    MemRData_In = rdata;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    set_mem(1'b0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rd  = '0;
    sb.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_idle();
    set_mem(1'b0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_rd  = '0;
    sb.delete();
    @(posedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h required 0", all_out);
    end
  endtask

  task automatic test_alu_op;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 3'd3, 1'b1, 1'b1, 1'b0);
    set_mem(1'b0, 16'h0);
    sb.push_back(mk(m_rd, 16'h1234, 3'd3, 1'b1, 1'b1, 1'b0));
    #1;
    checks++;
    if ({MemReq_Out, Stall_Out_ToPipe} !== 2'b00) begin
      errors++;
      $display("FAIL alu_no_req_stall: got %b required 00", {MemReq_Out, Stall_Out_ToPipe});
    end
    @(posedge clk);
    #1;
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL alu_wb: got %h required %h", obs, exp_wb);
    end
  endtask

  task automatic test_load_wait;
    int n_req;
    int n_stall;
    n_req   = 0;
    n_stall = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h5555, 3'd5, 1'b1, 1'b0, 1'b0);
    set_mem(1'b0, 16'h0);
    sb.push_back(mk(16'hBEEF, 16'h0040, 3'd5, 1'b1, 1'b0, 1'b0));
    m_rd = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 16'h0F00 + 16'(k), 16'hA5A5, 3'd1, 1'b0, 1'b1, 1'b0);
        if (k == 3) set_mem(1'b1, 16'hBEEF);
      end
      #1;
      if (MemReq_Out) n_req++;
      if (Stall_Out_ToPipe) n_stall++;
      checks++;
      if ({MemWr_Out, MemAddr_Out} !== {1'b0, 16'h0040}) begin
        errors++;
        $display("FAIL load_addr cycle %0d: got %b/%h required 0/0040", k, MemWr_Out, MemAddr_Out);
      end
      @(posedge clk);
    end
    #1;
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL load_wb: got %h required %h", obs, exp_wb);
    end
    checks++;
    if (n_req != 4 || n_stall != 3) begin
      errors++;
      $display("FAIL load_req_stall_cycles: got %0d/%0d required 4/3", n_req, n_stall);
    end
  endtask

  task automatic test_store_zero_wait;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h00FF, 3'd2, 1'b0, 1'b1, 1'b0);
    set_mem(1'b1, 16'hDEAD);
    sb.push_back(mk(m_rd, 16'h0010, 3'd2, 1'b0, 1'b1, 1'b0));
    #1;
    checks++;
    if ({MemReq_Out, MemWr_Out, MemAddr_Out, MemWData_Out, Stall_Out_ToPipe} !==
        {1'b1, 1'b1, 16'h0010, 16'h00FF, 1'b0}) begin
      errors++;
      $display("FAIL store_req: got %b %b %h %h %b required 1 1 0010 00ff 0",
               MemReq_Out, MemWr_Out, MemAddr_Out, MemWData_Out, Stall_Out_ToPipe);
    end
    @(posedge clk);
    #1;
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL store_wb: got %h required %h", obs, exp_wb);
    end
  endtask

  task automatic test_back_to_back;
    int          kind;
    int          lat;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rdat;
    logic [2:0]  dst;
    logic        sel;
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      lat  = (kind == 0) ? 0 : $urandom_range(0, 2);
      a    = 16'($urandom) & 16'hFFFE;
      d    = 16'($urandom);
      rdat = 16'($urandom);
      dst  = 3'($urandom);
      sel  = 1'($urandom);
      @(negedge clk);
      if (kind == 0) begin
        drive(1'b1, 1'b0, 1'b0, a, d, dst, 1'b1, 1'b1, 1'b0);
        sb.push_back(mk(m_rd, a, dst, 1'b1, 1'b1, 1'b0));
      end else if (kind == 1) begin
        drive(1'b1, 1'b1, 1'b0, a, d, dst, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(rdat, a, dst, 1'b1, 1'b0, 1'b0));
        m_rd = rdat;
      end else begin
        drive(1'b1, 1'b0, 1'b1, a, d, dst, 1'b0, sel, 1'b0);
        sb.push_back(mk(m_rd, a, dst, 1'b0, sel, 1'b0));
      end
      set_mem((kind != 0) && (lat == 0), (lat == 0) ? rdat : ~rdat);
      for (int c = 0; c < lat; c++) begin
        #1;
        checks++;
        if (Stall_Out_ToPipe !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall op %0d wait %0d: got %b required 1", i, c, Stall_Out_ToPipe);
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, ~a, ~d, ~dst, 1'b0, 1'b0, 1'b1);
        if (c == lat - 1) set_mem(1'b1, rdat);
      end
      #1;
      checks++;
      if (Stall_Out_ToPipe !== 1'b0) begin
        errors++;
        $display("FAIL b2b_final_stall op %0d: got %b required 0", i, Stall_Out_ToPipe);
      end
      @(posedge clk);
      #1;
      exp_wb = sb.pop_front();
      checks++;
      if (obs !== exp_wb) begin
        errors++;
        $display("FAIL b2b_wb op %0d kind %0d lat %0d: got %h required %h", i, kind, lat, obs, exp_wb);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err: got %b required 0", err);
    end
  endtask

  task automatic test_unaligned;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0, 3'd4, 1'b1, 1'b0, 1'b0);
    set_mem(1'b1, 16'h1357);
    sb.push_back(mk(16'h1357, 16'h0041, 3'd4, 1'b1, 1'b0, 1'b0));
    m_rd = 16'h1357;
    #1;
    checks++;
    if ({MemReq_Out, MemAddr_Out} !== {1'b1, 16'h0040}) begin
      errors++;
      $display("FAIL unaligned_addr: got %b/%h required 1/0040", MemReq_Out, MemAddr_Out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL unaligned_err: got %b required 1", err);
    end
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL unaligned_wb: got %h required %h", obs, exp_wb);
    end
    @(negedge clk);
    drive_idle();
    set_mem(1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", err);
    end
  endtask

  task automatic test_rw_conflict;
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0BAD, 16'h0, 3'd1, 1'b1, 1'b1, 1'b0);
    sb.push_back(mk(m_rd, 16'h0BAD, 3'd1, 1'b1, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    exp_wb = sb.pop_front();
    checks++;
    if ({obs, err} !== {exp_wb, 1'b0}) begin
      errors++;
      $display("FAIL pre_conflict: got %h/%b required %h/0", obs, err, exp_wb);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 16'h0022, 16'h0001, 3'd6, 1'b1, 1'b0, 1'b0);
    set_mem(1'b1, 16'h7777);
    sb.push_back(mk(m_rd, 16'h0BAD, 3'd1, 1'b0, 1'b1, 1'b0));
    #1;
    checks++;
    if ({MemReq_Out, Stall_Out_ToPipe} !== 2'b00) begin
      errors++;
      $display("FAIL conflict_no_req: got %b required 00", {MemReq_Out, Stall_Out_ToPipe});
    end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL conflict_err: got %b required 1", err);
    end
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL conflict_bubble: got %h required %h", obs, exp_wb);
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0, 3'd2, 1'b1, 1'b0, 1'b0);
    set_mem(1'b0, 16'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({MemReq_Out, Stall_Out_ToPipe} !== 2'b11) begin
      errors++;
      $display("FAIL mid_wait: got %b required 11", {MemReq_Out, Stall_Out_ToPipe});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h required 0", all_out);
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    m_rd  = '0;
    sb.delete();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0062, 16'h0, 3'd3, 1'b1, 1'b0, 1'b0);
    set_mem(1'b1, 16'h4242);
    sb.push_back(mk(16'h4242, 16'h0062, 3'd3, 1'b1, 1'b0, 1'b0));
    m_rd = 16'h4242;
    @(posedge clk);
    #1;
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL post_reset_load: got %h required %h", obs, exp_wb);
    end
  endtask

  task automatic test_halt;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h00AA, 16'h0, 3'd7, 1'b1, 1'b0, 1'b1);
    set_mem(1'b0, 16'h0);
    sb.push_back(mk(m_rd, 16'h00AA, 3'd7, 1'b1, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL halt_wb: got %h required %h", obs, exp_wb);
    end
    exp_wb = mk(m_rd, 16'h00AA, 3'd7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, (i % 2) == 0, (i % 2) == 1, 16'h0100 + 16'(2 * i), 16'hFFFF, 3'd1,
            1'b1, 1'b1, i == 2);
      set_mem(1'b1, 16'h9999);
      #1;
      checks++;
      if ({MemReq_Out, Stall_Out_ToPipe} !== 2'b00) begin
        errors++;
        $display("FAIL halted_req %0d: got %b required 00", i, {MemReq_Out, Stall_Out_ToPipe});
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== exp_wb) begin
        errors++;
        $display("FAIL halted_hold %0d: got %h required %h", i, obs, exp_wb);
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0);
    set_mem(1'b0, 16'h0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    repeat (TMO - 1) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b required 0", err);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({err, MemReq_Out, Stall_Out_ToPipe, WriteToReg_Out_ToWB} !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_fire: got %b required 1000",
               {err, MemReq_Out, Stall_Out_ToPipe, WriteToReg_Out_ToWB});
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0C0C, 16'h0, 3'd4, 1'b1, 1'b1, 1'b0);
    sb.push_back(mk(m_rd, 16'h0C0C, 3'd4, 1'b1, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    exp_wb = sb.pop_front();
    checks++;
    if (obs !== exp_wb) begin
      errors++;
      $display("FAIL post_timeout_op: got %h required %h", obs, exp_wb);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_store_zero_wait();
    test_back_to_back();
    test_unaligned();
    test_rw_conflict();
    test_reset_mid_access();
    test_halt();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 5-stage WISC-SP13 pipeline.
- Takes execute-stage results and performs loads/stores through a multi-cycle request/done data-memory handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the load data, ALU result and destination control for the write stage, which selects the writeback data.

Parameters:
- TIMEOUT_CYCLES, 64: cycles in WAIT without MemDone_In before the timeout error; only used with MEM_TIMEOUT_EN.

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
Valid_In_FromEx  input  1  execute stage holds a valid instruction
MemRead_In_FromEx  input  1  instruction is a load
MemWrite_In_FromEx  input  1  instruction is a store
ALUResult_In_FromEx  input  16  ALU result / memory address
WriteData_In_FromEx  input  16  store data
WR_In_FromEx  input  3  destination register
WriteToReg_In_FromEx  input  1  register write enable
RegWriteDataSel_In_FromEx  input  1  0 = memory data, 1 = ALU result
Halt_In_FromEx  input  1  HALT instruction
MemReq_Out  output  1  data-memory request
MemWr_Out  output  1  1 = write, 0 = read; valid with MemReq_Out
MemAddr_Out  output  16  memory address
MemWData_Out  output  16  store data
MemRData_In  input  16  load data; valid when MemDone_In = 1
MemDone_In  input  1  access complete this cycle
Stall_Out_ToPipe  output  1  freeze fetch/decode/execute and their pipeline registers
ReadData_Out_ToWB  output  16  registered load data
ALUResult_Out_ToWB  output  16  registered ALU result
WR_Out_ToWB  output  3  registered destination register
WriteToReg_Out_ToWB  output  1  registered write enable
RegWriteDataSel_Out_ToWB  output  1  registered writeback select
Halt_Out_ToWB  output  1  registered halt
err  output  1  sticky error flag

Behaviour:
- Reset (async, rst_n = 0): state IDLE; every output 0. Reset mid-access drops MemReq_Out at once and discards the access.
- States: IDLE, WAIT, HALTED.
- mem op = Valid_In_FromEx & (MemRead_In_FromEx | MemWrite_In_FromEx).
- IDLE, mem op present:
  - MemReq_Out = 1 combinationally, with MemAddr_Out/MemWData_Out/MemWr_Out taken from the inputs.
  - All execute inputs are captured into hold registers at the edge.
  - MemDone_In = 1 same cycle: MEM/WB loads at the edge, stay IDLE, Stall_Out_ToPipe = 0. Zero-wait access = 1-cycle latency.
  - Otherwise: go to WAIT; Stall_Out_ToPipe = 1 this cycle.
- WAIT:
  - MemReq_Out held at 1; address, data and direction come from the hold registers, so upstream changes are ignored.
  - Stall_Out_ToPipe = ~MemDone_In.
  - On MemDone_In: MEM/WB loads from hold registers plus MemRData_In; next state IDLE.
- MEM/WB load:
  - ReadData_Out_ToWB = MemRData_In for loads; unchanged for stores and non-memory ops.
  - All other _ToWB outputs copy their sources.
- IDLE, valid non-memory op: MEM/WB loads at the next edge, no stall.
- IDLE, Valid_In_FromEx = 0: bubble loads. WriteToReg_Out_ToWB = 0 and Halt_Out_ToWB = 0; data fields hold their value.
- Halt: a valid instruction with Halt_In_FromEx (non-memory) loads Halt_Out_ToWB = 1 and goes to HALTED. HALTED ignores all inputs, holds MEM/WB with WriteToReg_Out_ToWB forced 0 after the first cycle, and keeps MemReq_Out = 0. Exit only by reset.
- err (registered, sticky until reset) is set on:
  - a valid op with MemRead_In_FromEx & MemWrite_In_FromEx; it is treated as a bubble and no request is issued;
  - a mem op with ALUResult_In_FromEx[0] = 1 (unaligned); the access is still performed with bit 0 forced 0.
- MemDone_In while in IDLE with no request: ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without MemDone_In sets err, drops MemReq_Out, loads a bubble into MEM/WB, deasserts the stall and returns to IDLE.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely until MemDone_In.

Test Plan:
1. Reset then ADD-style op (Valid=1, ALUResult=0x1234, WR=3, WriteToReg=1, Sel=1) -> next edge: ALUResult_Out_ToWB = 0x1234, WR_Out_ToWB = 3, WriteToReg_Out_ToWB = 1; Stall_Out_ToPipe stays 0.
2. Load addr 0x0040, MemDone after 3 wait cycles with MemRData = 0xBEEF -> MemReq_Out high 4 cycles, stall high 3 cycles, then ReadData_Out_ToWB = 0xBEEF; upstream input changes during WAIT do not alter MemAddr_Out.
3. Store addr 0x0010, data 0x00FF, MemDone same cycle -> MemWr_Out = 1, MemWData_Out = 0x00FF; no stall; WriteToReg_Out_ToWB = 0 when input WriteToReg = 0.
4. Load to 0x0041 -> err = 1 next edge and stays 1; MemAddr_Out = 0x0040. Separately, a valid op with Read = Write = 1 -> err = 1, no MemReq_Out.
5. rst_n low during WAIT -> MemReq_Out and all outputs 0 immediately; after release, a new op completes normally.
6. HALT, then valid ops -> Halt_Out_ToWB = 1 and held; no MemReq_Out. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8, a load with no MemDone -> err = 1 after 8 WAIT cycles, stall released, state IDLE.
